// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
// Loading-side driver for a configuration (ccff) chain. Bitstream words arrive on a
// valid/ready stream and are shifted MSB-first into ccff_head. The bits that fall out
// of ccff_tail are gathered into readback words, first bit out in the MSB.
module ccff_chain_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en
);

  localparam int IDX_W = $clog2(WORD_W);
  localparam int COL_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LEN      = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LEN_M1   = CNT_W'(CHAIN_LEN - 1);
  localparam logic [COL_W-1:0] COL_FULL = COL_W'(WORD_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WORD_W-1:0] in_buf;
  logic              in_full;
  logic [IDX_W-1:0]  in_idx;
  logic [WORD_W-1:0] col_buf;
  logic [COL_W-1:0]  col_cnt;
  logic [COL_W-1:0]  col_pad;

  logic in_load, chain_done, col_full, col_word, shift, accept, xfer, enter_load;

  assign in_load    = (state == LOAD);
  assign chain_done = (bit_count == LEN);
  assign col_full   = (col_cnt == COL_FULL);
  assign col_word   = col_full | (chain_done & (col_cnt != '0));
  assign col_pad    = COL_FULL - col_cnt;
  assign shift      = in_load & in_full & ~chain_done & ~(col_full & rb_valid);
  assign accept     = bs_valid & bs_ready;
  assign xfer       = in_load & col_word & (~rb_valid | rb_ready);
  assign enter_load = start & (state != LOAD);

  assign busy          = in_load;
  assign done          = (state == DONE);
  assign bs_ready      = in_load & ~in_full & ~chain_done;
  assign ccff_head     = in_buf[WORD_W-1];
  assign ccff_shift_en = shift;

  // State register.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) state <= IDLE;
    else             state <= state_nxt;
  end

  // Next state: a pass ends once every chain bit is shifted and all readback has drained.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: if (chain_done && (col_cnt == '0) && !rb_valid) state_nxt = DONE;
      DONE: if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Input word buffer and bit counter: load on handshake, shift out MSB on each chain shift.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      in_buf    <= '0;
      in_full   <= 1'b0;
      in_idx    <= '0;
      bit_count <= '0;
    end else if (enter_load) begin
      in_buf    <= '0;
      in_full   <= 1'b0;
      in_idx    <= '0;
      bit_count <= '0;
    end else if (in_load) begin
      if (accept) begin
        in_buf  <= bs_data;
        in_full <= 1'b1;
        in_idx  <= IDX_LAST;
      end else if (shift) begin
        if ((bit_count == LEN_M1) || (in_idx == '0)) begin
          in_buf  <= '0;
          in_full <= 1'b0;
          in_idx  <= '0;
        end else begin
          in_buf <= in_buf << 1;
          in_idx <= in_idx - IDX_W'(1);
        end
      end
      if (shift) bit_count <= bit_count + CNT_W'(1);
    end
  end

  // Readback collector and output register: a full or final partial word moves out
  // left-aligned whenever the output slot is free or being emptied this cycle.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      col_buf  <= '0;
      col_cnt  <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else if (enter_load) begin
      col_buf <= '0;
      col_cnt <= '0;
    end else if (in_load) begin
      if (xfer) begin
        rb_data  <= col_buf << col_pad;
        rb_valid <= 1'b1;
        if (shift) begin
          col_buf <= {{(WORD_W-1){1'b0}}, ccff_tail};
          col_cnt <= COL_W'(1);
        end else begin
          col_buf <= '0;
          col_cnt <= '0;
        end
      end else begin
        if (rb_valid && rb_ready) rb_valid <= 1'b0;
        if (shift) begin
          col_buf <= {col_buf[WORD_W-2:0], ccff_tail};
          col_cnt <= col_cnt + COL_W'(1);
        end
      end
    end
  end

endmodule
